// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signal bundle for alu_cmd_sequencer.
// The sequencer takes the slave view; the environment (command source,
// ALU and result consumer) takes the master view.
interface alu_cmd_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    // Command stream
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic [15:0]              CMD_A;
    logic [15:0]              CMD_B;
    logic [3:0]               CMD_FUN;

    // ALU operand side
    logic [15:0]              ALU_A;
    logic [15:0]              ALU_B;
    logic [3:0]               ALU_FUN;

    // ALU result side (registered inside the ALU)
    logic [15:0]              ALU_OUT;
    logic                     Arith_Flag;
    logic                     Logic_Flag;
    logic                     CMP_Flag;
    logic                     Shift_Flag;

    // Result stream
    logic                     RES_VALID;
    logic                     RES_READY;
    logic [15:0]              RES_DATA;
    logic [3:0]               RES_FLAGS;
    logic [3:0]               RES_FUN;

    // Status
    logic                     BUSY;
    logic [$clog2(DEPTH):0]   CMD_COUNT;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        input  ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
        input  RES_READY,
        output CMD_READY, ALU_A, ALU_B, ALU_FUN,
        output RES_VALID, RES_DATA, RES_FLAGS, RES_FUN,
        output BUSY, CMD_COUNT
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_FUN,
        output ALU_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
        output RES_READY,
        input  CMD_READY, ALU_A, ALU_B, ALU_FUN,
        input  RES_VALID, RES_DATA, RES_FLAGS, RES_FUN,
        input  BUSY, CMD_COUNT
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a registered 16-bit ALU: buffers commands in a small
// FIFO, issues them one at a time, waits for the ALU's registered result and
// presents it on a valid/ready result port, strictly in command order.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    alu_cmd_sequencer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    // FIFO entry layout: {fun[3:0], a[15:0], b[15:0]}
    logic [35:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    logic [1:0]    state_q;
    logic [1:0]    state_d;

    logic          full;
    logic          empty;
    logic          cmd_ready;
    logic          push;
    logic          pop;
    logic [35:0]   head;

    logic [15:0]   alu_a_q;
    logic [15:0]   alu_b_q;
    logic [3:0]    alu_fun_q;
    logic [15:0]   res_data_q;
    logic [3:0]    res_flags_q;
    logic [3:0]    res_fun_q;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    // Readiness only depends on the current occupancy, so a same-cycle pop
    // never lets a push into a full FIFO.
    assign cmd_ready = RST & ~full;
    assign push      = bus.CMD_VALID & cmd_ready;
    assign head      = mem_q[rd_ptr_q];

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.CMD_FUN, bus.CMD_A, bus.CMD_B};
        end
    end

    // Occupancy next-state from push/pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Sequencer next-state and pop decision
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            // ALU registers its result at the end of this cycle
            ST_ISSUE: state_d = ST_WAIT;
            // Result is visible on ALU_OUT now and captured at the edge
            ST_WAIT:  state_d = ST_RESULT;
            ST_RESULT: begin
                if (bus.RES_READY) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU operand registers, loaded only on pop and held otherwise
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_fun_q <= '0;
        end else if (pop) begin
            {alu_fun_q, alu_a_q, alu_b_q} <= head;
        end
    end

    // Result capture at the end of WAIT; held through RESULT backpressure
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_fun_q   <= '0;
        end else if (state_q == ST_WAIT) begin
            res_data_q  <= bus.ALU_OUT;
            res_flags_q <= {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
            res_fun_q   <= alu_fun_q;
        end
    end

    assign bus.CMD_READY = cmd_ready;
    assign bus.ALU_A     = alu_a_q;
    assign bus.ALU_B     = alu_b_q;
    assign bus.ALU_FUN   = alu_fun_q;
    assign bus.RES_VALID = (state_q == ST_RESULT);
    assign bus.RES_DATA  = res_data_q;
    assign bus.RES_FLAGS = res_flags_q;
    assign bus.RES_FUN   = res_fun_q;
    assign bus.BUSY      = (state_q != ST_IDLE) | ~empty;
    assign bus.CMD_COUNT = count_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, the number of command FIFO entries (power of two, ≥2).
REQ-002 The block SHALL have port CLK  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port CMD_VALID  input  1  command present.
REQ-005 The block SHALL have port CMD_READY  output  1  command FIFO can accept.
REQ-006 The block SHALL have ports CMD_A  input  16, CMD_B  input  16, CMD_FUN  input  4, carrying the command operands and ALU opcode.
REQ-007 The block SHALL have ports ALU_A  output  16, ALU_B  output  16, ALU_FUN  output  4, all registered, which drive the 16-bit ALU inputs.
REQ-008 The block SHALL have ports ALU_OUT  input  16, plus Arith_Flag, Logic_Flag, CMP_Flag and Shift_Flag  input  1 each, carrying the registered ALU result and flags.
REQ-009 The block SHALL have port RES_VALID  output  1  result available.
REQ-010 The block SHALL have port RES_READY  input  1  consumer accepts result.
REQ-011 The block SHALL have ports RES_DATA  output  16, RES_FLAGS  output  4 {Arith,Logic,CMP,Shift}, and RES_FUN  output  4 (opcode echo).
REQ-012 The block SHALL have port BUSY  output  1, high when the state is not IDLE or the FIFO is non-empty.
REQ-013 The block SHALL have port CMD_COUNT  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 The FIFO SHALL push {CMD_FUN,CMD_A,CMD_B} on a rising edge where CMD_VALID && CMD_READY.
REQ-015 CMD_READY SHALL equal (CMD_COUNT < DEPTH) while RST is high; there SHALL be no push when full, even if a pop occurs in the same cycle.
REQ-016 A simultaneous push and pop SHALL leave CMD_COUNT unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESULT.
REQ-018 IDLE: if CMD_COUNT≠0, pop head into ALU_A/ALU_B/ALU_FUN and enter ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE SHALL last exactly one cycle (the ALU registers its result at the end of it) and then enter WAIT.
REQ-020 WAIT SHALL last exactly one cycle; at its ending edge, ALU_OUT, the flags and ALU_FUN SHALL be captured into RES_DATA, RES_FLAGS and RES_FUN, and the FSM SHALL enter RESULT.
REQ-021 RES_VALID SHALL be high exactly in RESULT; RES_DATA, RES_FLAGS and RES_FUN SHALL be held stable while RES_VALID && !RES_READY.
REQ-022 RESULT with RES_READY: if CMD_COUNT≠0, pop the next command and enter ISSUE (back-to-back); otherwise enter IDLE.
REQ-023 Latency from command acceptance into an idle empty block to RES_VALID SHALL be 3 cycles; with RES_READY held high, sustained throughput SHALL be one result per 3 cycles.
REQ-024 Results SHALL be delivered in command order; there SHALL be no loss or duplication.
REQ-025 ALU_A, ALU_B and ALU_FUN SHALL hold their last issued values until the next pop.
REQ-026 Opcodes SHALL be passed to the ALU unmodified, including 4'b1111; result and flags SHALL be captured verbatim, with no interpretation.

Reset
REQ-027 While RST is low, the block SHALL be asynchronously forced into: state=IDLE, FIFO pointers/count=0, ALU_A/ALU_B/ALU_FUN=0, RES_DATA=0, RES_FLAGS=0, RES_FUN=0, RES_VALID=0, CMD_READY=0, BUSY=0.
REQ-028 Reset asserted mid-operation SHALL discard all queued and in-flight commands; no stale result SHALL appear after release.
REQ-029 CMD_READY SHALL rise in the first cycle after RST is deasserted.

Verification
REQ-030 Single ADD: FUN=0000, A=3, B=13, RES_READY=1 -> RES_VALID high 3 cycles after acceptance for one cycle, RES_DATA=16, RES_FLAGS=1000, RES_FUN=0000.
REQ-031 Fill with RES_READY=0, CMD_VALID held high -> exactly DEPTH+1=5 commands accepted, then CMD_READY=0, CMD_COUNT=4, RES_VALID=1 and stable.
REQ-032 Ordered stream SUB(3,2), AND(3,13), GT(7,1), SHL(3,1) with RES_READY=1 -> RES_DATA 1, 1, 2, 6; RES_FLAGS 1000, 0100, 0010, 0001; in order, spaced 3 cycles apart.
REQ-033 Backpressure: RES_READY low for 10 cycles during RESULT -> RES_DATA/RES_FLAGS unchanged throughout; after release the queued results drain in order.
REQ-034 Reset in WAIT with 2 commands queued -> RES_VALID stays 0, CMD_COUNT=0, ALU_A=0; after release, one new ADD(1,1) yields RES_DATA=2.
REQ-035 Default opcode: FUN=1111, A=3, B=1 -> RES_DATA=0, RES_FLAGS=0000, RES_FUN=1111.
